slave_addr_burst_expander: RTL and testbench
============================================

// Module: slave_addr_burst_expander
// PURPOSE
//  Read-side consumer of the AXI4 slave's 46-bit address-command async FIFO
//  (first-word-fall-through off; read data valid one cycle after rd_en).
//  Pops one command at a time and expands it into per-beat addresses with a
//  valid/ready handshake for the slave back-end (memory / register bank).
//  Implements the AXI4 FIXED, INCR and WRAP burst address rules.
// PARAMETERS
//  ADDR_WIDTH   32  beat/command address width; arithmetic is modulo 2**ADDR_WIDTH
//  SIZE_LOG2    2   log2(bytes per beat); beat increment = 2**SIZE_LOG2
//  ID_WIDTH     4   transaction ID width
//  CMD_WIDTH    46  FIFO word width; must equal ID_WIDTH+2+8+ADDR_WIDTH
// PORTS
//  rd_clk      in   1           single clock (FIFO read clock)
//  rd_rst      in   1           asynchronous active-high reset
//  rd_en       out  1           FIFO pop strobe (combinational from state/rd_empty)
//  rd_empty    in   1           FIFO empty
//  rd_data     in   CMD_WIDTH   {id, burst[1:0], len[7:0], addr}, valid cycle after rd_en
//  beat_valid  out  1           beat address valid
//  beat_ready  in   1           back-end accepts beat
//  beat_addr   out  ADDR_WIDTH  address of current beat
//  beat_id     out  ID_WIDTH    ID of current burst
//  beat_idx    out  8           beat number within burst, 0..len
//  beat_last   out  1           current beat is beat len
//  busy        out  1           high in any state other than IDLE
// BEHAVIOUR
//  - Reset: state IDLE; beat_valid=0, beat_last=0, beat_addr=0, beat_id=0,
//    beat_idx=0, busy=0; rd_en=0 while rd_rst high. Reset mid-burst drops the
//    command in flight; the FIFO is reset by the same signal.
//  - FSM: IDLE -> FETCH -> LOAD -> BURST -> IDLE.
//    IDLE : rd_en = !rd_empty; if popped -> FETCH. rd_en only ever asserted here.
//    FETCH: wait state, rd_data becomes valid at the end of this cycle -> LOAD.
//    LOAD : register id/burst/len/addr, compute wrap mask -> BURST.
//    BURST: beat_valid=1; on beat_valid&&beat_ready advance; on handshake of
//           beat_last -> IDLE.
//  - Latency: rd_en in cycle N -> beat_valid first high in cycle N+3.
//    Min 4-cycle gap between last handshake of one burst and first beat of next.
//  - Handshake: beat_addr/id/idx/last stable while beat_valid && !beat_ready;
//    beat_valid never drops without a handshake (except reset).
//  - beat_idx: 0 on first beat, +1 per handshake; beat_last = (beat_idx == len).
//    len=0 -> single beat, beat_last high on first beat.
//  - Address, inc = 2**SIZE_LOG2:
//    FIXED (00): every beat = start addr.
//    INCR  (01): first beat = addr; next = aligned(addr)+k*inc, i.e. low
//                SIZE_LOG2 bits cleared after beat 0; wraps modulo 2**ADDR_WIDTH.
//    WRAP  (10): span = (len+1)*inc; low = (addr+k*inc) mod span inside the
//                span-aligned window; legal len only 1,3,7,15.
//    Reserved 11, or WRAP with illegal len: handled as INCR.
//  - No 4KB-boundary checks; the master guarantees legality.
//  - busy = (state != IDLE). A command is never popped while busy.
// TESTING
//  1 Reset: rd_rst=1 with rd_empty=0 -> rd_en=0, beat_valid=0, all outputs 0.
//  2 INCR len=3 addr=0x1000 id=5, beat_ready=1 -> beats 0x1000,0x1004,0x1008,
//    0x100C, beat_last on 4th, id=5; first beat_valid 3 cycles after rd_en.
//  3 WRAP len=3 addr=0x0000_1038 -> 0x1038,0x103C,0x1030,0x1034; last on 0x1034.
//  4 FIXED len=2 addr=0x20 with beat_ready toggling 1/0 -> three beats all 0x20,
//    outputs held while stalled, beat_idx 0,1,2.
//  5 INCR len=1 addr=0xFFFF_FFFC -> 0xFFFF_FFFC, 0x0000_0000 (wrap-around);
//    two commands queued -> second popped only after first beat_last handshake.
//  6 Assert rd_rst during beat 2 of len=7 -> next cycle beat_valid=0, busy=0;
//    after release a fresh command bursts correctly from beat_idx 0.

Source files
------------

// File: rtl/slave_addr_burst_expander.sv
// Pops one address command from the slave's command FIFO and expands it into
// per-beat addresses (FIXED / INCR / WRAP) with a valid/ready handshake.
module slave_addr_burst_expander #(
  parameter int ADDR_WIDTH = 32,
  parameter int SIZE_LOG2  = 2,
  parameter int ID_WIDTH   = 4,
  parameter int CMD_WIDTH  = 46
) (
  input  logic                  rd_clk,
  input  logic                  rd_rst,
  output logic                  rd_en,
  input  logic                  rd_empty,
  input  logic [CMD_WIDTH-1:0]  rd_data,
  output logic                  beat_valid,
  input  logic                  beat_ready,
  output logic [ADDR_WIDTH-1:0] beat_addr,
  output logic [ID_WIDTH-1:0]   beat_id,
  output logic [7:0]            beat_idx,
  output logic                  beat_last,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, FETCH, LOAD, BURST} state_t;
  typedef enum logic [1:0] {MODE_FIXED = 2'd0, MODE_INCR = 2'd1, MODE_WRAP = 2'd2} mode_t;

  localparam logic [ADDR_WIDTH-1:0] INC      = ADDR_WIDTH'(1) << SIZE_LOG2;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = INC - ADDR_WIDTH'(1);

  state_t                  state_reg;
  mode_t                   mode_reg;
  logic [7:0]              len_reg;
  logic [ADDR_WIDTH-1:0]   wrap_mask_reg;

  logic [ADDR_WIDTH-1:0]   cmd_addr;
  logic [7:0]              cmd_len;
  logic [1:0]              cmd_burst;
  logic [ID_WIDTH-1:0]     cmd_id;
  logic [ADDR_WIDTH-1:0]   cmd_span;
  logic [ADDR_WIDTH-1:0]   cmd_mask;
  logic                    cmd_wrap_ok;
  mode_t                   cmd_mode;
  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [7:0]              idx_inc;

  assign {cmd_id, cmd_burst, cmd_len, cmd_addr} = rd_data;

  // WRAP window is (len+1) beats wide; its low bits wrap, the rest stay fixed.
  assign cmd_span    = (ADDR_WIDTH'(cmd_len) + ADDR_WIDTH'(1)) << SIZE_LOG2;
  assign cmd_mask    = cmd_span - ADDR_WIDTH'(1);
  assign cmd_wrap_ok = (cmd_burst == 2'b10) &&
                       (cmd_len == 8'd1 || cmd_len == 8'd3 || cmd_len == 8'd7 || cmd_len == 8'd15);

  always_comb begin
    cmd_mode = MODE_INCR;
    if (cmd_burst == 2'b00)
      cmd_mode = MODE_FIXED;
    else if (cmd_wrap_ok)
      cmd_mode = MODE_WRAP;
  end

  always_comb begin
    next_addr = beat_addr;
    case (mode_reg)
      MODE_INCR: next_addr = (beat_addr & ~LOW_MASK) + INC;
      MODE_WRAP: next_addr = (beat_addr & ~wrap_mask_reg) | ((beat_addr + INC) & wrap_mask_reg);
      default:   next_addr = beat_addr;
    endcase
  end

  assign idx_inc = beat_idx + 8'd1;
  assign rd_en   = (state_reg == IDLE) && !rd_empty && !rd_rst;
  assign busy    = (state_reg != IDLE);

  always_ff @(posedge rd_clk or posedge rd_rst) begin
    if (rd_rst) begin
      state_reg     <= IDLE;
      mode_reg      <= MODE_FIXED;
      len_reg       <= 8'd0;
      wrap_mask_reg <= '0;
      beat_valid    <= 1'b0;
      beat_last     <= 1'b0;
      beat_addr     <= '0;
      beat_id       <= '0;
      beat_idx      <= 8'd0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (rd_en)
            state_reg <= FETCH;
        end
        FETCH: state_reg <= LOAD;
        LOAD: begin
          mode_reg      <= cmd_mode;
          len_reg       <= cmd_len;
          wrap_mask_reg <= cmd_mask;
          beat_addr     <= cmd_addr;
          beat_id       <= cmd_id;
          beat_idx      <= 8'd0;
          beat_last     <= (cmd_len == 8'd0);
          beat_valid    <= 1'b1;
          state_reg     <= BURST;
        end
        BURST: begin
          if (beat_ready) begin
            if (beat_last) begin
              beat_valid <= 1'b0;
              beat_last  <= 1'b0;
              state_reg  <= IDLE;
            end else begin
              beat_addr <= next_addr;
              beat_idx  <= idx_inc;
              beat_last <= (idx_inc == len_reg);
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_slave_addr_burst_expander.sv
// Scoreboard bench: commands go into a FIFO model, expected beats into a queue,
// and handshaken beats are compared against it in order.
module tb_slave_addr_burst_expander;

  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  id;
    logic [7:0]  idx;
    logic        last;
  } beat_t;

  typedef struct {
    beat_t b;
    int    cyc;
  } obs_t;

  logic        rd_clk;
  logic        rd_rst;
  logic        rd_en;
  logic        rd_empty;
  logic [45:0] rd_data;
  logic        beat_valid;
  logic        beat_ready;
  logic [31:0] beat_addr;
  logic [3:0]  beat_id;
  logic [7:0]  beat_idx;
  logic        beat_last;
  logic        busy;

  slave_addr_burst_expander dut (
    .rd_clk     (rd_clk),
    .rd_rst     (rd_rst),
    .rd_en      (rd_en),
    .rd_empty   (rd_empty),
    .rd_data    (rd_data),
    .beat_valid (beat_valid),
    .beat_ready (beat_ready),
    .beat_addr  (beat_addr),
    .beat_id    (beat_id),
    .beat_idx   (beat_idx),
    .beat_last  (beat_last),
    .busy       (busy)
  );

  initial rd_clk = 1'b0;
  always #5 rd_clk = ~rd_clk;

  int cyc = 0;
  always @(posedge rd_clk) cyc <= cyc + 1;

  // FIFO model: registered read, data valid the cycle after rd_en
  logic [45:0] cmd_mem [0:15];
  logic [4:0]  wr_ptr = 5'd0;
  logic [4:0]  rd_ptr = 5'd0;
  assign rd_empty = (wr_ptr == rd_ptr);
  always @(posedge rd_clk) begin
    if (rd_en) begin
      rd_data <= cmd_mem[rd_ptr[3:0]];
      rd_ptr  <= rd_ptr + 5'd1;
    end
  end

  // Monitor: sampled on the falling edge, away from the active edge
  obs_t obs_mem [0:63];
  int   obs_wr    = 0;
  int   obs_rd    = 0;
  int   rden_cyc  = 0;
  int   rise_cyc  = 0;
  int   bad_pop   = 0;
  logic prev_valid = 1'b0;
  always @(negedge rd_clk) begin
    if (rd_en) begin
      rden_cyc <= cyc;
      if (rd_empty || busy) bad_pop <= bad_pop + 1;
    end
    if (beat_valid && !prev_valid) rise_cyc <= cyc;
    prev_valid <= beat_valid;
    if (beat_valid && beat_ready) begin
      obs_mem[obs_wr % 64] <= '{b: '{addr: beat_addr, id: beat_id, idx: beat_idx, last: beat_last}, cyc: cyc};
      obs_wr <= obs_wr + 1;
    end
  end

  beat_t exp_q [$];
  int    pass_cnt  = 0;
  int    total_cnt = 0;

  function automatic string fmt(beat_t b);
    return $sformatf("addr=%h id=%h idx=%0d last=%b", b.addr, b.id, b.idx, b.last);
  endfunction

  // Queue a command in the FIFO and push the first 'keep' expected beats
  task automatic push_cmd(input logic [3:0] id, input logic [1:0] burst, input logic [7:0] len,
                          input logic [31:0] addr, input int keep);
    logic [31:0] span;
    logic [31:0] a;
    bit          wrap;
    cmd_mem[wr_ptr[3:0]] = {id, burst, len, addr};
    wr_ptr = wr_ptr + 5'd1;
    wrap = (burst == 2'b10) && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    span = (32'(len) + 32'd1) * 32'd4;
    for (int k = 0; k <= int'(len) && k < keep; k++) begin
      if (burst == 2'b00)
        a = addr;
      else if (wrap)
        a = (addr - addr % span) + ((addr % span + 32'(k) * 32'd4) % span);
      else if (k == 0)
        a = addr;
      else
        a = (addr & ~32'h3) + 32'(k) * 32'd4;
      exp_q.push_back('{addr: a, id: id, idx: 8'(k), last: (k == int'(len))});
    end
  endtask

  task automatic wait_obs(input int n, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (obs_wr - obs_rd >= n) begin
        ok = 1'b1;
        break;
      end
      @(posedge rd_clk); #1;
    end
    if (!ok) begin
      obs_rd = obs_wr;
      exp_q.delete();
    end
  endtask

  task automatic next_pair(output beat_t o, output beat_t e, output int c);
    o = obs_mem[obs_rd % 64].b;
    c = obs_mem[obs_rd % 64].cyc;
    obs_rd = obs_rd + 1;
    e = exp_q.pop_front();
  endtask

  task automatic test_reset();
    beat_t o, e;
    int    c;
    bit    ok;
    rd_rst = 1'b1;
    beat_ready = 1'b0;
    repeat (2) @(posedge rd_clk);
    #1 push_cmd(4'h3, 2'b00, 8'd0, 32'h44, 1);
    @(negedge rd_clk);
    total_cnt++;
    if (rd_en !== 1'b0) $display("FAIL reset_rd_en: got %b, expected 0", rd_en);
    else pass_cnt++;
    total_cnt++;
    if ({beat_valid, beat_last, busy, beat_addr, beat_id, beat_idx} !== 47'd0)
      $display("FAIL reset_outputs: got valid=%b last=%b busy=%b addr=%h id=%h idx=%0d, expected all 0",
               beat_valid, beat_last, busy, beat_addr, beat_id, beat_idx);
    else pass_cnt++;
    @(posedge rd_clk); #1;
    rd_rst = 1'b0;
    beat_ready = 1'b1;
    wait_obs(1, ok);
    total_cnt++;
    if (!ok) $display("FAIL reset_timeout: got fewer than 1 beat, expected 1");
    else pass_cnt++;
    for (int k = 0; k < 1 && ok; k++) begin
      next_pair(o, e, c);
      total_cnt++;
      if (o !== e) $display("FAIL reset_beat%0d: got %s, expected %s", k, fmt(o), fmt(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_incr();
    beat_t o, e;
    int    c;
    bit    ok;
    beat_ready = 1'b1;
    push_cmd(4'h5, 2'b01, 8'd3, 32'h1000, 4);
    wait_obs(4, ok);
    total_cnt++;
    if (!ok) $display("FAIL incr_timeout: got fewer than 4 beats, expected 4");
    else pass_cnt++;
    for (int k = 0; k < 4 && ok; k++) begin
      next_pair(o, e, c);
      total_cnt++;
      if (o !== e) $display("FAIL incr_beat%0d: got %s, expected %s", k, fmt(o), fmt(e));
      else pass_cnt++;
    end
    total_cnt++;
    if (rise_cyc - rden_cyc !== 3) $display("FAIL incr_latency: got %0d cycles, expected 3", rise_cyc - rden_cyc);
    else pass_cnt++;
    total_cnt++;
    if ({busy, beat_valid} !== 2'b00) $display("FAIL incr_idle_after: got busy=%b valid=%b, expected 0 0", busy, beat_valid);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    beat_t o, e;
    int    c;
    bit    ok;
    bit    seen;
    beat_ready = 1'b0;
    push_cmd(4'hB, 2'b10, 8'd3, 32'h0000_1038, 4);
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge rd_clk); #1;
      seen = beat_valid;
    end
    total_cnt++;
    if (busy !== 1'b1 || !seen) $display("FAIL wrap_busy: got busy=%b valid=%b, expected 1 1", busy, beat_valid);
    else pass_cnt++;
    beat_ready = 1'b1;
    wait_obs(4, ok);
    total_cnt++;
    if (!ok) $display("FAIL wrap_timeout: got fewer than 4 beats, expected 4");
    else pass_cnt++;
    for (int k = 0; k < 4 && ok; k++) begin
      next_pair(o, e, c);
      total_cnt++;
      if (o !== e) $display("FAIL wrap_beat%0d: got %s, expected %s", k, fmt(o), fmt(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_fixed_stall();
    beat_t       o, e;
    int          c;
    bit          ok;
    bit          held_v;
    logic [45:0] held;
    beat_ready = 1'b1;
    push_cmd(4'h6, 2'b00, 8'd2, 32'h20, 3);
    held_v = 1'b0;
    held   = '0;
    for (int i = 0; i < 40 && (obs_wr - obs_rd) < 3; i++) begin
      @(negedge rd_clk);
      if (held_v) begin
        total_cnt++;
        if ({beat_valid, beat_addr, beat_id, beat_idx, beat_last} !== held)
          $display("FAIL fixed_hold: got valid=%b addr=%h id=%h idx=%0d last=%b, expected %h held",
                   beat_valid, beat_addr, beat_id, beat_idx, beat_last, held);
        else pass_cnt++;
      end
      held_v = beat_valid && !beat_ready;
      held   = {beat_valid, beat_addr, beat_id, beat_idx, beat_last};
      @(posedge rd_clk); #1;
      beat_ready = ~beat_ready;
    end
    beat_ready = 1'b1;
    wait_obs(3, ok);
    total_cnt++;
    if (!ok) $display("FAIL fixed_timeout: got fewer than 3 beats, expected 3");
    else pass_cnt++;
    for (int k = 0; k < 3 && ok; k++) begin
      next_pair(o, e, c);
      total_cnt++;
      if (o !== e) $display("FAIL fixed_beat%0d: got %s, expected %s", k, fmt(o), fmt(e));
      else pass_cnt++;
    end
    wait_obs(0, ok);
    repeat (2) @(posedge rd_clk);
    #1;
  endtask

  task automatic test_back_to_back();
    beat_t o, e;
    int    c;
    int    c_last1;
    int    c_first2;
    bit    ok;
    beat_ready = 1'b1;
    push_cmd(4'h1, 2'b01, 8'd1, 32'hFFFF_FFFC, 2);
    push_cmd(4'h2, 2'b00, 8'd0, 32'h80, 1);
    wait_obs(3, ok);
    total_cnt++;
    if (!ok) $display("FAIL b2b_timeout: got fewer than 3 beats, expected 3");
    else pass_cnt++;
    c_last1  = 0;
    c_first2 = 0;
    for (int k = 0; k < 3 && ok; k++) begin
      next_pair(o, e, c);
      if (k == 1) c_last1 = c;
      if (k == 2) c_first2 = c;
      total_cnt++;
      if (o !== e) $display("FAIL b2b_beat%0d: got %s, expected %s", k, fmt(o), fmt(e));
      else pass_cnt++;
    end
    total_cnt++;
    if (rden_cyc <= c_last1) $display("FAIL b2b_pop_order: got second pop at cycle %0d, expected after %0d", rden_cyc, c_last1);
    else pass_cnt++;
    total_cnt++;
    if (c_first2 - c_last1 < 4) $display("FAIL b2b_gap: got %0d cycles, expected at least 4", c_first2 - c_last1);
    else pass_cnt++;
  endtask

  task automatic test_fallback();
    beat_t o, e;
    int    c;
    bit    ok;
    beat_ready = 1'b1;
    push_cmd(4'h7, 2'b11, 8'd2, 32'h102, 3);
    push_cmd(4'h8, 2'b10, 8'd2, 32'h108, 3);
    wait_obs(6, ok);
    total_cnt++;
    if (!ok) $display("FAIL fallback_timeout: got fewer than 6 beats, expected 6");
    else pass_cnt++;
    for (int k = 0; k < 6 && ok; k++) begin
      next_pair(o, e, c);
      total_cnt++;
      if (o !== e) $display("FAIL fallback_beat%0d: got %s, expected %s", k, fmt(o), fmt(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_midburst();
    beat_t o, e;
    int    c;
    bit    ok;
    bit    found;
    beat_ready = 1'b1;
    push_cmd(4'h9, 2'b01, 8'd7, 32'h3000, 2);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge rd_clk); #1;
      if (beat_valid && beat_idx == 8'd2) begin
        found = 1'b1;
        break;
      end
    end
    total_cnt++;
    if (!found) $display("FAIL midrst_reach_beat2: got no beat_idx 2, expected one");
    else pass_cnt++;
    rd_rst = 1'b1;
    @(negedge rd_clk);
    total_cnt++;
    if ({beat_valid, busy, beat_last, beat_idx} !== 11'd0)
      $display("FAIL midrst_cleared: got valid=%b busy=%b last=%b idx=%0d, expected all 0",
               beat_valid, busy, beat_last, beat_idx);
    else pass_cnt++;
    @(posedge rd_clk); #1;
    rd_rst = 1'b0;
    wait_obs(2, ok);
    total_cnt++;
    if (!ok) $display("FAIL midrst_timeout: got fewer than 2 beats, expected 2");
    else pass_cnt++;
    for (int k = 0; k < 2 && ok; k++) begin
      next_pair(o, e, c);
      total_cnt++;
      if (o !== e) $display("FAIL midrst_beat%0d: got %s, expected %s", k, fmt(o), fmt(e));
      else pass_cnt++;
    end
    push_cmd(4'hA, 2'b10, 8'd7, 32'h4014, 8);
    wait_obs(8, ok);
    total_cnt++;
    if (!ok) $display("FAIL postrst_timeout: got fewer than 8 beats, expected 8");
    else pass_cnt++;
    for (int k = 0; k < 8 && ok; k++) begin
      next_pair(o, e, c);
      total_cnt++;
      if (o !== e) $display("FAIL postrst_beat%0d: got %s, expected %s", k, fmt(o), fmt(e));
      else pass_cnt++;
    end
  endtask

  task automatic test_protocol();
    total_cnt++;
    if (bad_pop !== 0) $display("FAIL pop_rules: got %0d pops while empty or busy, expected 0", bad_pop);
    else pass_cnt++;
  endtask

  initial begin
    rd_rst     = 1'b1;
    beat_ready = 1'b0;
    test_reset();
    test_incr();
    test_wrap();
    test_fixed_stall();
    test_back_to_back();
    test_fallback();
    test_reset_midburst();
    test_protocol();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
